// File: rtl/mips_mem_pkg.sv
// ---------------------------------------------------------------------------
// Package: mips_mem_pkg
// Purpose: Shared widths and type definitions for the main-memory block port
//          arbiter.
//          - ADDR_W / BLK_W : default byte-address and block widths
//          - TIMEOUT_CYC    : default watchdog limit in XFER cycles
//          - arb_state_t    : arbiter FSM states
//          - owner_t        : which cache side owns the current transfer
// ---------------------------------------------------------------------------
package mips_mem_pkg;

    localparam int ADDR_W      = 32;
    localparam int BLK_W       = 256;
    localparam int TIMEOUT_CYC = 255;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        XFER = 2'd1,
        DONE = 2'd2
    } arb_state_t;

    typedef enum logic {
        OWN_I = 1'b0,
        OWN_D = 1'b1
    } owner_t;

endpackage

// File: rtl/blk_mem_arbiter_rr_arb2.sv
// ---------------------------------------------------------------------------
// Module: rr_arb2
// Purpose: Two-way combinational round-robin arbiter.
// Ports:
//   req        in   [1:0]   request vector, bit 0 = I side, bit 1 = D side
//   last_grant in   owner_t side that received the previous grant
//   grant      out  [1:0]   one-hot grant, same bit order as req
// ---------------------------------------------------------------------------
module rr_arb2
    import mips_mem_pkg::*;
(
    input  logic [1:0] req,
    input  owner_t     last_grant,
    output logic [1:0] grant
);

    // A lone requester always wins; on a tie the side that did not win last
    // time gets the grant.
    always_comb begin
        grant = 2'b00;
        case (req)
            2'b01:   grant = 2'b01;
            2'b10:   grant = 2'b10;
            2'b11:   grant = (last_grant == OWN_I) ? 2'b10 : 2'b01;
            default: grant = 2'b00;
        endcase
    end

endmodule

// File: rtl/blk_mem_arbiter.sv
// ---------------------------------------------------------------------------
// Module: blk_mem_arbiter
// Purpose: Shares the single block-wide main-memory port between the I-cache
//          refill path and the D-cache read/writeback path. One transaction
//          at a time, round-robin on ties, with a watchdog that aborts a
//          transfer the memory never acknowledges.
// Ports:
//   CLK, RESET                  clock (rising edge), async active-low reset
//   i_req, i_addr               I-side block read request
//   i_done, i_rdata             I completion pulse and held refill data
//   d_req, d_we, d_addr,d_wdata D-side block read / writeback request
//   d_done, d_rdata             D completion pulse and held read data
//   mem_valid, mem_we,
//   mem_addr, mem_wdata         memory command (block-aligned address)
//   mem_rdata, mem_ready        memory response
//   busy                        FSM is not IDLE
//   timeout_err                 pulse on watchdog abort, alongside done
// ---------------------------------------------------------------------------
module blk_mem_arbiter #(
    parameter int ADDR_W      = mips_mem_pkg::ADDR_W,
    parameter int BLK_W       = mips_mem_pkg::BLK_W,
    parameter int TIMEOUT_CYC = mips_mem_pkg::TIMEOUT_CYC
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic              i_req,
    input  logic [ADDR_W-1:0] i_addr,
    output logic              i_done,
    output logic [BLK_W-1:0]  i_rdata,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [BLK_W-1:0]  d_wdata,
    output logic              d_done,
    output logic [BLK_W-1:0]  d_rdata,
    output logic              mem_valid,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [BLK_W-1:0]  mem_wdata,
    input  logic [BLK_W-1:0]  mem_rdata,
    input  logic              mem_ready,
    output logic              busy,
    output logic              timeout_err
);

    import mips_mem_pkg::*;

    localparam int WD_W = $clog2(TIMEOUT_CYC + 1);
    localparam logic [WD_W-1:0] WD_MAX = WD_W'(TIMEOUT_CYC);
    localparam logic [ADDR_W-1:0] BLK_MASK = {{(ADDR_W-5){1'b1}}, 5'b00000};

    arb_state_t        state_q, state_d;
    owner_t            owner_q, owner_d;
    owner_t            lastGrant_q, lastGrant_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              we_q, we_d;
    logic [BLK_W-1:0]  wdata_q, wdata_d;
    logic [BLK_W-1:0]  iRdata_q, iRdata_d;
    logic [BLK_W-1:0]  dRdata_q, dRdata_d;
    logic [WD_W-1:0]   watchdog_q, watchdog_d;
    logic              timedOut_q, timedOut_d;
    logic [1:0]        grant;

    rr_arb2 u_rr_arb2 (
        .req        ({d_req, i_req}),
        .last_grant (lastGrant_q),
        .grant      (grant)
    );

    // State and datapath registers. An asynchronous reset lands in IDLE, so
    // every state-decoded output (mem_valid, done, busy) drops at once.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state_q     <= IDLE;
            owner_q     <= OWN_I;
            lastGrant_q <= OWN_I;
            addr_q      <= '0;
            we_q        <= 1'b0;
            wdata_q     <= '0;
            iRdata_q    <= '0;
            dRdata_q    <= '0;
            watchdog_q  <= '0;
            timedOut_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            owner_q     <= owner_d;
            lastGrant_q <= lastGrant_d;
            addr_q      <= addr_d;
            we_q        <= we_d;
            wdata_q     <= wdata_d;
            iRdata_q    <= iRdata_d;
            dRdata_q    <= dRdata_d;
            watchdog_q  <= watchdog_d;
            timedOut_q  <= timedOut_d;
        end
    end

    // Next-state logic. Requests are only looked at in IDLE, mem_ready only
    // in XFER. The watchdog aborts when it has counted TIMEOUT_CYC XFER
    // cycles and the memory still has not answered; an abort leaves the
    // owner's read data untouched.
    always_comb begin
        state_d     = state_q;
        owner_d     = owner_q;
        lastGrant_d = lastGrant_q;
        addr_d      = addr_q;
        we_d        = we_q;
        wdata_d     = wdata_q;
        iRdata_d    = iRdata_q;
        dRdata_d    = dRdata_q;
        watchdog_d  = watchdog_q;
        timedOut_d  = timedOut_q;

        case (state_q)
            IDLE: begin
                watchdog_d = '0;
                timedOut_d = 1'b0;
                if (grant[1]) begin
                    state_d = XFER;
                    owner_d = OWN_D;
                    addr_d  = d_addr;
                    we_d    = d_we;
                    wdata_d = d_wdata;
                end else if (grant[0]) begin
                    state_d = XFER;
                    owner_d = OWN_I;
                    addr_d  = i_addr;
                    we_d    = 1'b0;
                end
            end
            XFER: begin
                if (mem_ready) begin
                    state_d = DONE;
                    if (!we_q) begin
                        if (owner_q == OWN_D) begin
                            dRdata_d = mem_rdata;
                        end else begin
                            iRdata_d = mem_rdata;
                        end
                    end
                end else if (watchdog_q == WD_MAX) begin
                    state_d    = DONE;
                    timedOut_d = 1'b1;
                end else begin
                    watchdog_d = watchdog_q + WD_W'(1);
                end
            end
            DONE: begin
                state_d     = IDLE;
                lastGrant_d = owner_q;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Outputs are decoded from registered state only; the address is
    // presented block-aligned.
    always_comb begin
        mem_valid   = (state_q == XFER);
        mem_we      = (state_q == XFER) && we_q;
        mem_addr    = addr_q & BLK_MASK;
        mem_wdata   = wdata_q;
        busy        = (state_q != IDLE);
        i_done      = (state_q == DONE) && (owner_q == OWN_I);
        d_done      = (state_q == DONE) && (owner_q == OWN_D);
        timeout_err = (state_q == DONE) && timedOut_q;
        i_rdata     = iRdata_q;
        d_rdata     = dRdata_q;
    end

endmodule
